// File: rtl/tbuart_core.sv
// Bench-side 8N1 UART partner: receives bytes from the chip's UART TX and
// transmits bytes to its UART RX under a start/busy/clear handshake.
module tbuart_core #(
  parameter int CLKS_PER_BIT = 4167
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       ser_rx,
  output logic       ser_tx,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_clear_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_WAIT_REL
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_shreg;

  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_shreg;
  logic             rx_s1;
  logic             rx_s2;
  logic             rx_armed;

  // Transmitter: one frame per rising request; a held request is not repeated
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      tx_state     <= TX_IDLE;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shreg     <= '0;
      ser_tx       <= 1'b1;
      tx_busy      <= 1'b0;
      tx_clear_req <= 1'b0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_start) begin
            tx_state     <= TX_START;
            tx_shreg     <= tx_data;
            tx_busy      <= 1'b1;
            tx_clear_req <= 1'b0;
            ser_tx       <= 1'b0;
            tx_cnt       <= '0;
          end
        end
        TX_START: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_state <= TX_DATA;
            ser_tx   <= tx_shreg[0];
            tx_shreg <= {1'b0, tx_shreg[7:1]};
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              tx_state <= TX_STOP;
              ser_tx   <= 1'b1;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              ser_tx   <= tx_shreg[0];
              tx_shreg <= {1'b0, tx_shreg[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == LAST) begin
            tx_cnt   <= '0;
            tx_state <= TX_WAIT_REL;
            tx_busy  <= 1'b0;
            ser_tx   <= 1'b1;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_WAIT_REL: begin
          if (!tx_start) begin
            tx_state     <= TX_IDLE;
            tx_clear_req <= 1'b1;
          end
        end
        default: begin
          tx_state <= TX_IDLE;
          ser_tx   <= 1'b1;
          tx_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Receiver: 2-flop synchronizer, mid-bit sampling; needs idle-high before re-arming
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rx_s1        <= 1'b1;
      rx_s2        <= 1'b1;
      rx_state     <= RX_IDLE;
      rx_armed     <= 1'b0;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shreg     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_s1        <= ser_rx;
      rx_s2        <= rx_s1;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_armed) begin
            if (rx_s2) rx_armed <= 1'b1;
          end else if (!rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            // A high line at mid-start means the edge was a glitch
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= '0;
            rx_shreg <= {rx_s2, rx_shreg[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            rx_armed <= 1'b0;
            if (rx_s2) begin
              rx_data  <= rx_shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tbuart_core.sv
// Directed bench for tbuart_core at CLKS_PER_BIT=8: reset, TX framing,
// handshake loopback, RX glitch/frame error and full-duplex operation.
module tb_tbuart_core;

  localparam int CPB = 8;

  logic       clock = 1'b0;
  logic       resetb;
  logic       ser_rx;
  logic       ser_tx;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_clear_req;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;

  logic       loopback;
  logic       rx_drive;
  logic [7:0] rx_q[$];
  int         err_cnt;
  int         vectors;
  int         miscompares;

  assign ser_rx = loopback ? ser_tx : rx_drive;

  always #5 clock = ~clock;

  tbuart_core #(.CLKS_PER_BIT(CPB)) dut (
    .clock        (clock),
    .resetb       (resetb),
    .ser_rx       (ser_rx),
    .ser_tx       (ser_tx),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_clear_req (tx_clear_req),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  always @(negedge clock) begin
    if (rx_valid === 1'b1) rx_q.push_back(rx_data);
    if (rx_frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_busy(input logic level);
    int n = 0;
    while (tx_busy !== level && n < 200) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (tx_busy !== level) begin
      miscompares++;
      $display("FAIL wait_busy: tx_busy=%b, wanted %b within 200 cycles", tx_busy, level);
    end
  endtask

  task automatic wait_clear();
    int n = 0;
    while (tx_clear_req !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (tx_clear_req !== 1'b1) begin
      miscompares++;
      $display("FAIL wait_clear: tx_clear_req=%b, wanted 1 within 200 cycles", tx_clear_req);
    end
  endtask

  task automatic send_byte(input logic [7:0] d);
    @(negedge clock);
    tx_data  = d;
    tx_start = 1'b1;
    wait_busy(1'b1);
    tx_data = ~d;
    wait_busy(1'b0);
    tx_start = 1'b0;
    wait_clear();
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic stop);
    @(negedge clock);
    rx_drive = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx_drive = d[i];
      repeat (CPB) @(negedge clock);
    end
    rx_drive = stop;
    repeat (CPB) @(negedge clock);
    rx_drive = 1'b1;
    repeat (2 * CPB) @(negedge clock);
  endtask

  task automatic capture_tx(output logic [7:0] d);
    int n = 0;
    d = 8'h00;
    while (tx_busy !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    repeat (CPB / 2 - 1) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clock);
      d[i] = ser_tx;
    end
  endtask

  task automatic test_reset();
    resetb   = 1'b0;
    tx_start = 1'b1;
    tx_data  = 8'hA5;
    loopback = 1'b0;
    rx_drive = 1'b1;
    repeat (5) @(negedge clock);
    vectors++;
    if (ser_tx !== 1'b1) begin miscompares++; $display("FAIL reset_ser_tx: got %b want 1", ser_tx); end
    vectors++;
    if (tx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    vectors++;
    if (tx_clear_req !== 1'b0) begin miscompares++; $display("FAIL reset_clear_req: got %b want 0", tx_clear_req); end
    vectors++;
    if (rx_data !== 8'h00) begin miscompares++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
    vectors++;
    if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin
      miscompares++; $display("FAIL reset_rx_flags: got valid=%b err=%b want 0 0", rx_valid, rx_frame_err);
    end
    resetb = 1'b1;
    @(negedge clock);
    vectors++;
    if (tx_busy !== 1'b1) begin miscompares++; $display("FAIL reset_release_busy: got %b want 1", tx_busy); end
    vectors++;
    if (ser_tx !== 1'b0) begin miscompares++; $display("FAIL reset_release_start: got %b want 0", ser_tx); end
    wait_busy(1'b0);
    tx_start = 1'b0;
    wait_clear();
  endtask

  task automatic test_single_tx();
    logic [9:0] frame;
    logic [9:0] bad;
    int         busy_cnt;
    int         extra;
    frame    = 10'b1000011110;
    bad      = '0;
    busy_cnt = 0;
    extra    = 0;
    @(negedge clock);
    tx_data  = 8'h0F;
    tx_start = 1'b1;
    @(negedge clock);
    vectors++;
    if (tx_clear_req !== 1'b0) begin miscompares++; $display("FAIL single_clear_drop: got %b want 0", tx_clear_req); end
    for (int k = 0; k < 10 * CPB; k++) begin
      if (k > 0) @(negedge clock);
      if (ser_tx !== frame[k / CPB]) bad[k / CPB] = 1'b1;
      if (tx_busy === 1'b1) busy_cnt++;
    end
    for (int b = 0; b < 10; b++) begin
      vectors++;
      if (bad[b]) begin miscompares++; $display("FAIL single_bit%0d: ser_tx did not hold %b for %0d cycles", b, frame[b], CPB); end
    end
    @(negedge clock);
    vectors++;
    if (busy_cnt != 10 * CPB || tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL single_busy_len: got %0d cycles, busy now %b; want 80 cycles then 0", busy_cnt, tx_busy);
    end
    for (int k = 0; k < 60; k++) begin
      @(negedge clock);
      if (tx_busy !== 1'b0 || ser_tx !== 1'b1) extra++;
    end
    vectors++;
    if (extra != 0) begin miscompares++; $display("FAIL single_no_repeat: got %0d active cycles want 0", extra); end
    vectors++;
    if (tx_clear_req !== 1'b0) begin miscompares++; $display("FAIL single_clear_held: got %b want 0", tx_clear_req); end
    tx_start = 1'b0;
    @(negedge clock);
    vectors++;
    if (tx_clear_req !== 1'b1) begin miscompares++; $display("FAIL single_clear_rise: got %b want 1", tx_clear_req); end
  endtask

  task automatic test_loopback();
    logic [7:0] seq [8];
    logic [7:0] got;
    seq = '{8'h0F, 8'h3D, 8'h10, 8'h33, 8'h0F, 8'h3D, 8'h10, 8'h33};
    loopback = 1'b1;
    rx_q.delete();
    err_cnt = 0;
    for (int i = 0; i < 8; i++) send_byte(seq[i]);
    repeat (20) @(negedge clock);
    vectors++;
    if (rx_q.size() != 8 || err_cnt != 0) begin
      miscompares++; $display("FAIL loop_count: got %0d bytes %0d errors want 8 bytes 0 errors", rx_q.size(), err_cnt);
    end
    for (int i = 0; i < 8; i++) begin
      got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
      vectors++;
      if (got !== seq[i]) begin miscompares++; $display("FAIL loop_byte%0d: got %h want %h", i, got, seq[i]); end
    end
    loopback = 1'b0;
  endtask

  task automatic test_rx_glitch();
    rx_drive = 1'b1;
    rx_q.delete();
    err_cnt = 0;
    @(negedge clock);
    rx_drive = 1'b0;
    repeat (CPB / 4) @(negedge clock);
    rx_drive = 1'b1;
    repeat (12 * CPB) @(negedge clock);
    vectors++;
    if (rx_q.size() != 0 || err_cnt != 0) begin
      miscompares++; $display("FAIL glitch: got %0d bytes %0d errors want 0 0", rx_q.size(), err_cnt);
    end
  endtask

  task automatic test_bad_stop();
    rx_q.delete();
    err_cnt = 0;
    drive_rx(8'h5A, 1'b1);
    vectors++;
    if (rx_q.size() != 1 || rx_data !== 8'h5A) begin
      miscompares++; $display("FAIL badstop_prior: got %0d bytes data %h want 1 byte 5a", rx_q.size(), rx_data);
    end
    rx_q.delete();
    drive_rx(8'hAB, 1'b0);
    vectors++;
    if (err_cnt != 1) begin miscompares++; $display("FAIL badstop_err: got %0d pulses want 1", err_cnt); end
    vectors++;
    if (rx_q.size() != 0 || rx_data !== 8'h5A) begin
      miscompares++; $display("FAIL badstop_data: got %0d valids data %h want 0 valids data 5a", rx_q.size(), rx_data);
    end
  endtask

  task automatic test_full_duplex();
    logic [7:0] tx_seen;
    rx_q.delete();
    err_cnt = 0;
    fork
      send_byte(8'h33);
      drive_rx(8'h40, 1'b1);
      capture_tx(tx_seen);
    join
    vectors++;
    if (tx_seen !== 8'h33) begin miscompares++; $display("FAIL duplex_tx: got %h want 33", tx_seen); end
    vectors++;
    if (rx_q.size() != 1 || err_cnt != 0 || rx_data !== 8'h40) begin
      miscompares++; $display("FAIL duplex_rx: got %0d bytes data %h errors %0d want 1 byte 40 no errors", rx_q.size(), rx_data, err_cnt);
    end
    // reset during the start bit of a new frame
    @(negedge clock);
    tx_data  = 8'hFF;
    tx_start = 1'b1;
    @(negedge clock);
    vectors++;
    if (ser_tx !== 1'b0 || tx_busy !== 1'b1) begin
      miscompares++; $display("FAIL midtx_pre: got ser_tx=%b busy=%b want 0 1", ser_tx, tx_busy);
    end
    #2;
    resetb = 1'b0;
    #1;
    vectors++;
    if (ser_tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL midtx_reset: got ser_tx=%b busy=%b want 1 0", ser_tx, tx_busy);
    end
    tx_start = 1'b0;
    repeat (3) @(negedge clock);
    vectors++;
    if (rx_data !== 8'h00 || tx_clear_req !== 1'b0) begin
      miscompares++; $display("FAIL midtx_state: got rx_data=%h clear=%b want 00 0", rx_data, tx_clear_req);
    end
    resetb = 1'b1;
    repeat (5) @(negedge clock);
    vectors++;
    if (ser_tx !== 1'b1 || tx_busy !== 1'b0) begin
      miscompares++; $display("FAIL midtx_after: got ser_tx=%b busy=%b want 1 0", ser_tx, tx_busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    err_cnt     = 0;
    test_reset();
    test_single_tx();
    test_loopback();
    test_rx_glitch();
    test_bad_stop();
    test_full_duplex();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
